divider_core: RTL and testbench

//   Multi-cycle 32-bit integer divider for the Citrus CPU execute stage (DIV/DIVU).

---
 rtl/divider_core.sv | 214 +++++++++++++++++++++
 tb/tb_divider_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_core.sv
// -----------------------------------------------------------------------------
// divider_core
//   Multi-cycle integer divider for the execute stage (DIV / DIVU).
//   Radix-2 restoring division. It produces one quotient bit per clock, so a
//   division takes WIDTH iterations. Signed operands are reduced to
//   magnitudes, divided as unsigned values, and the signs are restored on the
//   last iteration. The results are held until the next division completes.
//
// Ports
//   clock   in   1      rising-edge clock
//   reset   in   1      synchronous active-high reset
//   a       in   WIDTH  dividend, captured when a division starts
//   b       in   WIDTH  divisor, captured when a division starts
//   start   in   1      level-sampled request, honoured only while idle
//   symbol  in   1      1 = signed (two's complement), 0 = unsigned
//   busy    out  1      high while a division is in progress
//   q       out  WIDTH  quotient (registered)
//   r       out  WIDTH  remainder (registered)
// -----------------------------------------------------------------------------
module divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             symbol,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    // Counter wide enough to hold WIDTH-1 for any WIDTH >= 2.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] VAL_ONES = {WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + VAL_ONE;
    endfunction

    // Magnitude of an operand. In unsigned mode the operand is returned as is.
    // The most negative value maps onto its own bit pattern, and that pattern
    // is read as an unsigned magnitude, so the magnitude path cannot overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Registers
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] dvd_q,      dvd_d;      // dividend bits out, quotient bits in
    logic [WIDTH-1:0] rem_q,      rem_d;      // partial remainder
    logic             neg_quo_q,  neg_quo_d;  // quotient must be negated
    logic             neg_rem_q,  neg_rem_d;  // remainder must be negated
    logic             div_zero_q, div_zero_d; // captured divisor was zero
    logic [WIDTH-1:0] a_raw_q,    a_raw_d;    // raw dividend, returned on divide by zero
    logic [WIDTH-1:0] quo_q,      quo_d;      // published quotient
    logic [WIDTH-1:0] rmd_q,      rmd_d;      // published remainder

    // One restoring step.
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] dvd_step_s;

    // One restoring-division step: shift {rem, dividend} left by one bit,
    // then try to subtract the divisor.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
        trial_s     = rem_shift_s - {1'b0, dvs_q};
        // The extra top bit of the trial difference is its sign.
        trial_ok_s  = ~trial_s[WIDTH];
        if (trial_ok_s) begin
            rem_step_s = trial_s[WIDTH-1:0];
        end else begin
            rem_step_s = rem_shift_s[WIDTH-1:0];
        end
        dvd_step_s  = {dvd_q[WIDTH-2:0], trial_ok_s};
    end

    // Next-state logic: operand capture, iteration and result write-back.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        quo_d      = quo_q;
        rmd_d      = rmd_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Capture everything now. The inputs may change freely
                    // while the division runs.
                    dvd_d      = magnitude(a, symbol);
                    dvs_d      = magnitude(b, symbol);
                    rem_d      = VAL_ZERO;
                    neg_quo_d  = symbol & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = symbol & a[WIDTH-1];
                    div_zero_d = (b == VAL_ZERO);
                    a_raw_d    = a;
                    cnt_d      = CNT_ZERO;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                rem_d = rem_step_s;
                dvd_d = dvd_step_s;
                if (cnt_q == CNT_LAST) begin
                    // Final step: restore the signs and publish the results.
                    // The published q and r are not cleared when a division
                    // starts; they change only here.
                    if (div_zero_q) begin
                        quo_d = VAL_ONES;
                        rmd_d = a_raw_q;
                    end else begin
                        if (neg_quo_q) begin
                            quo_d = negate(dvd_step_s);
                        end else begin
                            quo_d = dvd_step_s;
                        end
                        if (neg_rem_q) begin
                            rmd_d = negate(rem_step_s);
                        end else begin
                            rmd_d = rem_step_s;
                        end
                    end
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. A reset aborts any division in progress and clears
    // the published results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            busy_q     <= 1'b0;
            dvs_q      <= VAL_ZERO;
            dvd_q      <= VAL_ZERO;
            rem_q      <= VAL_ZERO;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= VAL_ZERO;
            quo_q      <= VAL_ZERO;
            rmd_q      <= VAL_ZERO;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
        end
    end

    assign busy = busy_q;
    assign q    = quo_q;
    assign r    = rmd_q;

endmodule

// File: tb/tb_divider_core.sv
// -----------------------------------------------------------------------------
// tb_divider_core
//   Scoreboard bench for divider_core. The stimulus tasks push the expected
//   {q, r, busy length} into a queue when they issue a division. The expected
//   values come from native integer division. A monitor pops and compares an
//   entry each time busy falls. While a division runs, the monitor also checks
//   that the previous results hold steady.
// -----------------------------------------------------------------------------
module tb_divider_core;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cycles;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start;
    logic         symbol;
    logic         busy;
    logic [W-1:0] q;
    logic [W-1:0] r;

    int   checks    = 0;
    int   errors    = 0;
    int   issued    = 0;
    int   completed = 0;
    exp_t exp_q[$];

    divider_core #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .start  (start),
        .symbol (symbol),
        .busy   (busy),
        .q      (q),
        .r      (r)
    );

    always #5 clock = ~clock;

    // Reference: native integer division with the divide-by-zero rule.
    // Truncation toward zero and the sign of the remainder follow the
    // language's own signed / and %.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sym);
        exp_t   e;
        longint la;
        longint lb;
        e.cycles = W;
        if (bv == 32'h0000_0000) begin
            e.q = 32'hFFFF_FFFF;
            e.r = av;
        end else if (!sym) begin
            e.q = av / bv;
            e.r = av % bv;
        end else begin
            la  = longint'($signed(av));
            lb  = longint'($signed(bv));
            e.q = 32'(la / lb);
            e.r = 32'(la % lb);
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge.
    initial begin : monitor
        int   busy_cycles;
        bit   prev_busy;
        bit   hold_bad;
        exp_t e;
        logic [W-1:0] last_q;
        logic [W-1:0] last_r;
        busy_cycles = 0;
        prev_busy   = 1'b0;
        hold_bad    = 1'b0;
        last_q      = 32'h0000_0000;
        last_r      = 32'h0000_0000;
        forever begin
            @(negedge clock);
            if (busy === 1'b1) begin
                busy_cycles++;
                if (q !== last_q || r !== last_r) hold_bad = 1'b1;
            end else if (prev_busy) begin
                completed++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: busy fell with nothing outstanding (q=%h r=%h)", q, r);
                end else begin
                    e = exp_q.pop_front();
                    checks += 4;
                    if (q !== e.q) begin
                        errors++;
                        $display("FAIL q: got %h expected %h", q, e.q);
                    end
                    if (r !== e.r) begin
                        errors++;
                        $display("FAIL r: got %h expected %h", r, e.r);
                    end
                    if (busy_cycles != e.cycles) begin
                        errors++;
                        $display("FAIL latency: got %0d busy cycles expected %0d", busy_cycles, e.cycles);
                    end
                    if (hold_bad) begin
                        errors++;
                        $display("FAIL hold: q/r changed during run, expected %h/%h held", last_q, last_r);
                    end
                    last_q = e.q;
                    last_r = e.r;
                end
                busy_cycles = 0;
                hold_bad    = 1'b0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // Waits until the DUT is idle, with a bound. Called and returns at posedge+2.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b expected 0 after %0d cycles", busy, n);
        end
    endtask

    // Issues one division. start stays high for `hold` edges. If `mutate` is
    // set, the operands are scrambled after capture.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sym, input int hold, input bit mutate);
        wait_idle();
        a      = av;
        b      = bv;
        symbol = sym;
        start  = 1'b1;
        exp_q.push_back(model(av, bv, sym));
        issued++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #2;
            if (mutate) begin
                a      = $urandom;
                b      = $urandom;
                symbol = ~symbol;
            end
        end
        start = 1'b0;
    endtask

    // Keeps start high across a completion, so a second division launches
    // as soon as the DUT returns to idle.
    task automatic back_to_back(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                                input logic [W-1:0] a2, input logic [W-1:0] b2, input logic s2);
        int n;
        wait_idle();
        a = a1; b = b1; symbol = s1; start = 1'b1;
        exp_q.push_back(model(a1, b1, s1));
        issued++;
        @(posedge clock);
        #2;
        a = a2; b = b2; symbol = s2;
        exp_q.push_back(model(a2, b2, s2));
        issued++;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    // Asserts reset on iteration 10 of a division. Nothing is published for
    // the aborted division; q and r read zero afterwards.
    task automatic abort_run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sym);
        exp_t e;
        wait_idle();
        a = av; b = bv; symbol = sym; start = 1'b1;
        e        = model(av, bv, sym);
        e.q      = 32'h0000_0000;
        e.r      = 32'h0000_0000;
        e.cycles = 10;
        exp_q.push_back(e);
        issued++;
        @(posedge clock);
        #2;
        start = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #2;
        end
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    // Watchdog bound on the whole run.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset  = 1'b1;
        start  = 1'b0;
        a      = 32'h0000_0000;
        b      = 32'h0000_0000;
        symbol = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (q !== 32'h0000_0000) begin errors++; $display("FAIL reset_q: got %h expected 00000000", q); end
        if (r !== 32'h0000_0000) begin errors++; $display("FAIL reset_r: got %h expected 00000000", r); end
        @(posedge clock);
        #2;

        // Directed corner cases.
        issue(32'h8000_0000, 32'h7D5F_8A74, 1'b0, 1, 1'b0);
        issue(32'h8000_0000, 32'h7D5F_8A74, 1'b1, 1, 1'b0);
        issue(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1, 1'b0);
        issue(32'h1234_5678, 32'h0000_0000, 1'b0, 1, 1'b0);
        issue(32'h1234_5678, 32'h0000_0000, 1'b1, 1, 1'b0);
        issue(32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
        issue(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1, 1'b0);
        issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 3, 1'b1);
        back_to_back(32'h0000_0064, 32'h0000_0007, 1'b0, 32'hFFFF_FF9C, 32'h0000_0007, 1'b1);
        abort_run(32'h7654_3210, 32'h0000_0011, 1'b0);
        issue(32'h7654_3210, 32'h0000_0011, 1'b0, 1, 1'b0);

        // Random operands, biased toward small, zero and negative divisors.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'h0000_0000;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'h0000_0000 - 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(posedge clock);
        #2;
        checks += 2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d results never completed, expected 0", exp_q.size());
        end
        if (completed != issued) begin
            errors++;
            $display("FAIL count: got %0d completions expected %0d", completed, issued);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
